// File: rtl/window_manager.sv
// Register-window controller: SAVE/RESTORE moves Cwp, checks Wim, and spills/fills or traps.
// Optional feature macro WIN_AUTO_SPILL_EN: defined = spill/fill via memory, undefined = trap.
//
// state     | meaning
// IDLE      | waiting for Wim_Ld / Save / Restore
// SPILL_RD  | read r16+i of target window from PortA into the write-data register
// SPILL_WR  | memory write of one register, waits for MOC
// FILL_RD   | memory read of one register, waits for MOC
// FILL_WR   | load the fetched word into r16+i of target window
// COMMIT    | Done pulse; Cwp and Wim update at the exiting edge
module window_manager #(
  parameter logic [31:0] SPILL_BASE = 32'h0000_0F00
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        Save,
  input  logic        Restore,
  input  logic        Wim_Ld,
  input  logic [3:0]  Wim_In,
  output logic [1:0]  Cwp,
  output logic [3:0]  Wim,
  output logic        Busy,
  output logic        Done,
  output logic        Trap,
  output logic [1:0]  Trap_Type,
  output logic        Rf_Own,
  output logic [1:0]  Rf_Win,
  output logic [4:0]  Rf_Sel,
  output logic        Rf_Ld,
  input  logic [31:0] Rf_Data_In,
  output logic [31:0] Rf_Data_Out,
  output logic        Mem_Req,
  output logic        Mem_Rw,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_Wdata,
  input  logic [31:0] Mem_Rdata,
  input  logic        MOC
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_COMMIT   = 3'd5;
`ifdef WIN_AUTO_SPILL_EN
  localparam logic [2:0] ST_SPILL_RD = 3'd1;
  localparam logic [2:0] ST_SPILL_WR = 3'd2;
  localparam logic [2:0] ST_FILL_RD  = 3'd3;
  localparam logic [2:0] ST_FILL_WR  = 3'd4;

  localparam logic [1:0] K_NONE  = 2'd0;
  localparam logic [1:0] K_SPILL = 2'd1;
  localparam logic [1:0] K_FILL  = 2'd2;
`endif

  logic [2:0]  state_q, state_d;
  logic [1:0]  cwp_q, cwp_d;
  logic [3:0]  wim_q, wim_d;
  logic [1:0]  n_q, n_d;
  logic        trap_q, trap_d;
  logic [1:0]  trap_type_q, trap_type_d;
  logic [1:0]  tgt;

`ifdef WIN_AUTO_SPILL_EN
  logic [3:0]  idx_q, idx_d;
  logic [1:0]  kind_q, kind_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdout_q, rdout_d;
`endif

  // Save has priority when both requests arrive together
  assign tgt = Save ? (cwp_q - 2'd1) : (cwp_q + 2'd1);

  always_comb begin
    state_d     = state_q;
    cwp_d       = cwp_q;
    wim_d       = wim_q;
    n_d         = n_q;
    trap_d      = 1'b0;
    trap_type_d = trap_type_q;
`ifdef WIN_AUTO_SPILL_EN
    idx_d       = idx_q;
    kind_d      = kind_q;
    wdata_d     = wdata_q;
    rdout_d     = rdout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Wim_Ld) begin
          wim_d = Wim_In;
        end else if (Save || Restore) begin
          n_d = tgt;
          if (!wim_q[tgt]) begin
            state_d = ST_COMMIT;
`ifdef WIN_AUTO_SPILL_EN
            kind_d  = K_NONE;
`endif
          end else begin
`ifdef WIN_AUTO_SPILL_EN
            idx_d = 4'd0;
            if (Save) begin
              state_d = ST_SPILL_RD;
              kind_d  = K_SPILL;
            end else begin
              state_d = ST_FILL_RD;
              kind_d  = K_FILL;
            end
`else
            trap_d      = 1'b1;
            trap_type_d = Save ? 2'b01 : 2'b10;
`endif
          end
        end
      end
`ifdef WIN_AUTO_SPILL_EN
      ST_SPILL_RD: begin
        wdata_d = Rf_Data_In;
        state_d = ST_SPILL_WR;
      end
      ST_SPILL_WR: begin
        if (MOC) begin
          if (idx_q == 4'd15) begin
            state_d = ST_COMMIT;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_SPILL_RD;
          end
        end
      end
      ST_FILL_RD: begin
        if (MOC) begin
          rdout_d = Mem_Rdata;
          state_d = ST_FILL_WR;
        end
      end
      ST_FILL_WR: begin
        if (idx_q == 4'd15) begin
          state_d = ST_COMMIT;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = ST_FILL_RD;
        end
      end
`endif
      ST_COMMIT: begin
        state_d = ST_IDLE;
        cwp_d   = n_q;
`ifdef WIN_AUTO_SPILL_EN
        if (kind_q == K_SPILL) begin
          wim_d = {wim_q[0], wim_q[3:1]};
        end else if (kind_q == K_FILL) begin
          wim_d = {wim_q[2:0], wim_q[3]};
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q     <= ST_IDLE;
      cwp_q       <= 2'b11;
      wim_q       <= 4'b0001;
      n_q         <= 2'b00;
      trap_q      <= 1'b0;
      trap_type_q <= 2'b00;
`ifdef WIN_AUTO_SPILL_EN
      idx_q       <= 4'd0;
      kind_q      <= K_NONE;
      wdata_q     <= 32'd0;
      rdout_q     <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      cwp_q       <= cwp_d;
      wim_q       <= wim_d;
      n_q         <= n_d;
      trap_q      <= trap_d;
      trap_type_q <= trap_type_d;
`ifdef WIN_AUTO_SPILL_EN
      idx_q       <= idx_d;
      kind_q      <= kind_d;
      wdata_q     <= wdata_d;
      rdout_q     <= rdout_d;
`endif
    end
  end

  assign Cwp       = cwp_q;
  assign Wim       = wim_q;
  assign Busy      = (state_q != ST_IDLE);
  assign Done      = (state_q == ST_COMMIT);
  assign Trap      = trap_q;
  assign Trap_Type = trap_type_q;

`ifdef WIN_AUTO_SPILL_EN
  logic rf_own;
  logic mem_req;

  assign rf_own      = (state_q == ST_SPILL_RD) || (state_q == ST_FILL_WR);
  assign mem_req     = (state_q == ST_SPILL_WR) || (state_q == ST_FILL_RD);

  assign Rf_Own      = rf_own;
  assign Rf_Win      = rf_own ? n_q : 2'b00;
  assign Rf_Sel      = rf_own ? {1'b1, idx_q} : 5'd0;
  assign Rf_Ld       = (state_q == ST_FILL_WR);
  assign Rf_Data_Out = rdout_q;
  // n and i are frozen while a request is pending, so the address is stable
  assign Mem_Req     = mem_req;
  assign Mem_Rw      = (state_q == ST_FILL_RD);
  assign Mem_Addr    = mem_req ? (SPILL_BASE + {24'd0, n_q, idx_q, 2'b00}) : 32'd0;
  assign Mem_Wdata   = wdata_q;
`else
  logic unused_inputs;

  assign unused_inputs = ^{Rf_Data_In, Mem_Rdata, MOC, SPILL_BASE};

  assign Rf_Own      = 1'b0;
  assign Rf_Win      = 2'b00;
  assign Rf_Sel      = 5'd0;
  assign Rf_Ld       = 1'b0;
  assign Rf_Data_Out = 32'd0;
  assign Mem_Req     = 1'b0;
  assign Mem_Rw      = 1'b0;
  assign Mem_Addr    = 32'd0;
  assign Mem_Wdata   = 32'd0;
`endif

endmodule

// File: tb/tb_window_manager.sv
// Directed self-checking bench for window_manager; covers both WIN_AUTO_SPILL_EN builds.
`timescale 1ns/1ps
module tb_window_manager;

  logic        Clk = 1'b0;
  logic        Clr = 1'b0;
  logic        Save = 1'b0;
  logic        Restore = 1'b0;
  logic        Wim_Ld = 1'b0;
  logic [3:0]  Wim_In = 4'd0;
  logic [1:0]  Cwp;
  logic [3:0]  Wim;
  logic        Busy, Done, Trap;
  logic [1:0]  Trap_Type;
  logic        Rf_Own;
  logic [1:0]  Rf_Win;
  logic [4:0]  Rf_Sel;
  logic        Rf_Ld;
  logic [31:0] Rf_Data_In;
  logic [31:0] Rf_Data_Out;
  logic        Mem_Req, Mem_Rw;
  logic [31:0] Mem_Addr, Mem_Wdata, Mem_Rdata;
  logic        MOC = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  window_manager #(.SPILL_BASE(32'h0000_0F00)) dut (
    .Clk(Clk), .Clr(Clr), .Save(Save), .Restore(Restore),
    .Wim_Ld(Wim_Ld), .Wim_In(Wim_In), .Cwp(Cwp), .Wim(Wim),
    .Busy(Busy), .Done(Done), .Trap(Trap), .Trap_Type(Trap_Type),
    .Rf_Own(Rf_Own), .Rf_Win(Rf_Win), .Rf_Sel(Rf_Sel), .Rf_Ld(Rf_Ld),
    .Rf_Data_In(Rf_Data_In), .Rf_Data_Out(Rf_Data_Out),
    .Mem_Req(Mem_Req), .Mem_Rw(Mem_Rw), .Mem_Addr(Mem_Addr),
    .Mem_Wdata(Mem_Wdata), .Mem_Rdata(Mem_Rdata), .MOC(MOC)
  );

  always #5 Clk = ~Clk;

  // Register file returns a word tagged with the selected window/register
  assign Rf_Data_In = {16'hC0DE, 9'd0, Rf_Win, Rf_Sel};
  assign Mem_Rdata  = 32'h5A00_0000 ^ Mem_Addr;

  // Memory responder with programmable MOC latency, plus transaction logs
  int moc_delay = 0;
  int wait_cnt = 0;
  int wr_n = 0, rd_n = 0, ld_n = 0, unstable = 0;
  logic [31:0] wr_addr [128];
  logic [31:0] wr_data [128];
  logic [31:0] rd_addr [128];
  logic [31:0] ld_data [128];
  logic [6:0]  ld_tag  [128];
  logic [31:0] held_addr, held_wdata;
  logic        held_rw;

  always @(negedge Clk) begin
    if (Mem_Req) begin
      if (wait_cnt == 0) begin
        held_addr  = Mem_Addr;
        held_wdata = Mem_Wdata;
        held_rw    = Mem_Rw;
      end else if (Mem_Addr !== held_addr || Mem_Wdata !== held_wdata || Mem_Rw !== held_rw) begin
        unstable++;
      end
      if (wait_cnt >= moc_delay) begin
        MOC = 1'b1;
        if (Mem_Rw) begin
          rd_addr[rd_n & 127] = Mem_Addr;
          rd_n++;
        end else begin
          wr_addr[wr_n & 127] = Mem_Addr;
          wr_data[wr_n & 127] = Mem_Wdata;
          wr_n++;
        end
      end else begin
        MOC = 1'b0;
        wait_cnt++;
      end
    end else begin
      MOC = 1'b0;
      wait_cnt = 0;
    end
    if (Rf_Ld) begin
      ld_tag[ld_n & 127]  = {Rf_Win, Rf_Sel};
      ld_data[ld_n & 127] = Rf_Data_Out;
      ld_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Drive a request before edge E0; returns #1 into cycle E0+1
  task automatic req(input logic s, input logic r);
    @(negedge Clk);
    Save = s;
    Restore = r;
    @(posedge Clk);
    #1;
    Save = 1'b0;
    Restore = 1'b0;
  endtask

  task automatic load_wim(input logic [3:0] v);
    @(negedge Clk);
    Wim_Ld = 1'b1;
    Wim_In = v;
    @(posedge Clk);
    #1;
    Wim_Ld = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge Clk);
    Clr = 1'b0;
    @(negedge Clk);
    Clr = 1'b1;
  endtask

  // k = cycle index after E0 at which Done is seen (300 means it never came)
  task automatic wait_done(output int k);
    k = 1;
    while (Done !== 1'b1 && k < 300) begin
      tick();
      k++;
    end
  endtask

  initial begin
    int k;
    int base_w, base_r, base_l;

    repeat (2) @(posedge Clk);
    #1;
    chk("rst_cwp", Cwp, 2'b11);
    chk("rst_wim", Wim, 4'b0001);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_trap", Trap, 1'b0);
    chk("rst_trap_type", Trap_Type, 2'b00);
    chk("rst_mem_req", Mem_Req, 1'b0);
    chk("rst_mem_addr", Mem_Addr, 32'd0);
    chk("rst_rf_own", Rf_Own, 1'b0);
    chk("rst_rf_sel", Rf_Sel, 5'd0);
    chk("rst_rf_ld", Rf_Ld, 1'b0);
    @(negedge Clk);
    Clr = 1'b1;

    req(1'b1, 1'b0);
    chk("save1_done", Done, 1'b1);
    chk("save1_busy", Busy, 1'b1);
    chk("save1_cwp_hold", Cwp, 2'd3);
    tick();
    chk("save1_done_off", Done, 1'b0);
    chk("save1_busy_off", Busy, 1'b0);
    chk("save1_cwp", Cwp, 2'd2);

    req(1'b1, 1'b0);
    chk("save2_done", Done, 1'b1);
    chk("save2_mem_req", Mem_Req, 1'b0);
    tick();
    chk("save2_cwp", Cwp, 2'd1);
    chk("save2_wim", Wim, 4'b0001);

`ifdef WIN_AUTO_SPILL_EN
    base_w = wr_n;
    req(1'b1, 1'b0);
    chk("spill_rf_own", Rf_Own, 1'b1);
    chk("spill_rf_win", Rf_Win, 2'd0);
    chk("spill_rf_sel", Rf_Sel, 5'd16);
    chk("spill_rf_ld", Rf_Ld, 1'b0);
    wait_done(k);
    chk("spill_done_cycle", k, 33);
    chk("spill_write_count", wr_n - base_w, 16);
    for (int i = 0; i < 16; i++) begin
      chk("spill_addr", wr_addr[(base_w + i) & 127], 32'h0000_0F00 + 4 * i);
      chk("spill_data", wr_data[(base_w + i) & 127], 32'hC0DE_0010 + i);
    end
    tick();
    chk("spill_cwp", Cwp, 2'd0);
    chk("spill_wim", Wim, 4'b1000);
    chk("spill_trap", Trap, 1'b0);
    chk("spill_busy_off", Busy, 1'b0);

    reset_pulse();
    base_r = rd_n;
    base_l = ld_n;
    req(1'b0, 1'b1);
    chk("fill_mem_req", Mem_Req, 1'b1);
    chk("fill_mem_rw", Mem_Rw, 1'b1);
    chk("fill_mem_addr", Mem_Addr, 32'h0000_0F00);
    wait_done(k);
    chk("fill_done_cycle", k, 33);
    chk("fill_read_count", rd_n - base_r, 16);
    chk("fill_ld_count", ld_n - base_l, 16);
    for (int i = 0; i < 16; i++) begin
      chk("fill_addr", rd_addr[(base_r + i) & 127], 32'h0000_0F00 + 4 * i);
      chk("fill_ld_tag", ld_tag[(base_l + i) & 127], 32'd16 + i);
      chk("fill_ld_data", ld_data[(base_l + i) & 127], 32'h5A00_0F00 + 4 * i);
    end
    tick();
    chk("fill_cwp", Cwp, 2'd0);
    chk("fill_wim", Wim, 4'b0010);

    reset_pulse();
    load_wim(4'b0100);
    chk("dly_wim_load", Wim, 4'b0100);
    moc_delay = 3;
    base_w = wr_n;
    unstable = 0;
    req(1'b1, 1'b0);
    wait_done(k);
    chk("dly_done_cycle", k, 81);
    chk("dly_unstable", unstable, 0);
    chk("dly_write_count", wr_n - base_w, 16);
    chk("dly_first_addr", wr_addr[base_w & 127], 32'h0000_0F80);
    chk("dly_first_data", wr_data[base_w & 127], 32'hC0DE_0050);
    chk("dly_last_addr", wr_addr[(base_w + 15) & 127], 32'h0000_0FBC);
    tick();
    chk("dly_cwp", Cwp, 2'd2);
    chk("dly_wim", Wim, 4'b0010);
    moc_delay = 0;
`else
    req(1'b1, 1'b0);
    chk("ovf_trap", Trap, 1'b1);
    chk("ovf_trap_type", Trap_Type, 2'b01);
    chk("ovf_done", Done, 1'b0);
    chk("ovf_busy", Busy, 1'b0);
    chk("ovf_mem_req", Mem_Req, 1'b0);
    chk("ovf_cwp", Cwp, 2'd1);
    chk("ovf_wim", Wim, 4'b0001);
    tick();
    chk("ovf_trap_off", Trap, 1'b0);
    chk("ovf_type_held", Trap_Type, 2'b01);
    chk("ovf_cwp_after", Cwp, 2'd1);

    req(1'b0, 1'b1);
    chk("rest1_done", Done, 1'b1);
    tick();
    chk("rest1_cwp", Cwp, 2'd2);
    req(1'b0, 1'b1);
    tick();
    chk("rest2_cwp", Cwp, 2'd3);

    req(1'b0, 1'b1);
    chk("unf_trap", Trap, 1'b1);
    chk("unf_trap_type", Trap_Type, 2'b10);
    chk("unf_done", Done, 1'b0);
    tick();
    chk("unf_trap_off", Trap, 1'b0);
    chk("unf_cwp", Cwp, 2'd3);
    chk("unf_wim", Wim, 4'b0001);
`endif

    reset_pulse();
    @(negedge Clk);
    Save = 1'b1;
    Restore = 1'b1;
    Wim_Ld = 1'b1;
    Wim_In = 4'b0100;
    @(posedge Clk);
    #1;
    Save = 1'b0;
    Restore = 1'b0;
    Wim_Ld = 1'b0;
    chk("ld_prio_wim", Wim, 4'b0100);
    chk("ld_prio_cwp", Cwp, 2'd3);
    chk("ld_prio_done", Done, 1'b0);
    chk("ld_prio_busy", Busy, 1'b0);
    tick();
    chk("ld_prio_done2", Done, 1'b0);

    load_wim(4'b0001);
    req(1'b1, 1'b1);
    chk("both_done", Done, 1'b1);
    Wim_Ld = 1'b1;
    Wim_In = 4'b1111;
    tick();
    Wim_Ld = 1'b0;
    chk("both_cwp_save_wins", Cwp, 2'd2);
    chk("busy_ld_ignored", Wim, 4'b0001);

`ifdef WIN_AUTO_SPILL_EN
    load_wim(4'b0010);
    moc_delay = 3;
    req(1'b1, 1'b0);
    repeat (2) tick();
    chk("clr_pre_mem_req", Mem_Req, 1'b1);
    #2;
    Clr = 1'b0;
    #1;
    chk("clr_mem_req", Mem_Req, 1'b0);
    chk("clr_mem_addr", Mem_Addr, 32'd0);
    chk("clr_rf_own", Rf_Own, 1'b0);
`else
    load_wim(4'b0100);
    req(1'b1, 1'b0);
    chk("clr_pre_busy", Busy, 1'b1);
    #2;
    Clr = 1'b0;
    #1;
    chk("clr_done", Done, 1'b0);
    chk("clr_mem_req", Mem_Req, 1'b0);
`endif
    chk("clr_busy", Busy, 1'b0);
    chk("clr_cwp", Cwp, 2'b11);
    chk("clr_wim", Wim, 4'b0001);
    moc_delay = 0;
    @(negedge Clk);
    Clr = 1'b1;

    req(1'b1, 1'b0);
    chk("post_clr_done", Done, 1'b1);
    tick();
    chk("post_clr_cwp", Cwp, 2'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
